// File: rtl/myminimac_pkg.sv
// Shared definitions for the myminimac transmit path.
// Contents: FSM state encoding (3 bits), MTU/MINLEN defaults, EOF marker byte,
// and a saturating 11-bit increment helper for the sent-byte counter.
package myminimac_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StUnpack = 3'd2,
      StPad    = 3'd3,
      StLast   = 3'd4
   } tx_state_e;

   localparam logic [10:0] MtuDefault    = 11'd1530;
   localparam logic [6:0]  MinlenDefault = 7'd60;
   localparam logic [7:0]  EofMarker     = 8'h00;

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

endpackage

// File: rtl/myminimac_tx_unpack.sv
// 32-to-8 big-endian word shifter for the transmit path.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load, din   - capture a fetched word and restart at byte 0 ([31:24])
//   shift_en    - a byte is being offered downstream this cycle
//   full        - downstream cannot accept; byte index holds
//   dout        - currently selected byte
//   idx         - current byte index (0 = most significant byte)
module myminimac_tx_unpack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] din,
   input  logic        shift_en,
   input  logic        full,
   output logic [7:0]  dout,
   output logic [1:0]  idx
);

   logic [31:0] data_q;
   logic [1:0]  idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         idx_q  <= '0;
      end else if (load) begin
         data_q <= din;
         idx_q  <= 2'd0;
      end else if (shift_en && !full) begin
         idx_q <= idx_q + 2'd1;
      end
   end

   always_comb begin
      dout = data_q[31:24];
      unique case (idx_q)
         2'd0: dout = data_q[31:24];
         2'd1: dout = data_q[23:16];
         2'd2: dout = data_q[15:8];
         2'd3: dout = data_q[7:0];
         default: dout = data_q[31:24];
      endcase
   end

   assign idx = idx_q;

endmodule

// File: rtl/myminimac_tx.sv
// Minimal MAC transmit engine: fetches frame words over a Wishbone read master
// and pushes them byte-by-byte (big-endian) into the RMII tx FIFO, ending each
// frame with an EOF marker push.
// Optional feature: define MYMINIMAC_TX_PAD_EN to zero-pad short frames to MINLEN.
// Ports:
//   sys_clk, sys_rst          - clock, asynchronous active-low reset
//   tx_valid/tx_adr/tx_count  - frame descriptor (word address, length in bytes)
//   tx_next, tx_done          - per-word fetch pulse, end-of-frame pulse
//   wbm_*                     - Wishbone read master
//   fifo_we/data/eof/full     - byte push toward the tx FIFO
module myminimac_tx
   import myminimac_pkg::*;
#(
   parameter logic [10:0] MTU    = MtuDefault,
   parameter logic [6:0]  MINLEN = MinlenDefault
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        tx_valid,
   input  logic [29:0] tx_adr,
   input  logic [10:0] tx_count,
   output logic        tx_next,
   output logic        tx_done,
   output logic [31:0] wbm_adr_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        fifo_we,
   output logic [7:0]  fifo_data,
   output logic        fifo_eof,
   input  logic        fifo_full
);

   tx_state_e   state_q, state_d;
   logic [29:0] adr_q, adr_d;
   logic [10:0] remaining_q, remaining_d;
   logic        armed_q;
   logic        load;
   logic        unpack_en;
   logic [7:0]  unpack_byte;
   logic [1:0]  byte_idx;
`ifdef MYMINIMAC_TX_PAD_EN
   logic [10:0] sent_q, sent_d;
`else
   // MINLEN is inert without padding.
   if (MINLEN == 7'd0) begin : g_minlen_inert
   end
`endif

   myminimac_tx_unpack u_unpack (
      .clk      (sys_clk),
      .rst_n    (sys_rst),
      .load     (load),
      .din      (wbm_dat_i),
      .shift_en (unpack_en),
      .full     (fifo_full),
      .dout     (unpack_byte),
      .idx      (byte_idx)
   );

   assign wbm_adr_o = {adr_q, 2'b00};

   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      remaining_d = remaining_q;
      wbm_cyc_o   = 1'b0;
      wbm_stb_o   = 1'b0;
      fifo_we     = 1'b0;
      fifo_data   = 8'h00;
      fifo_eof    = 1'b0;
      tx_next     = 1'b0;
      tx_done     = 1'b0;
      load        = 1'b0;
      unpack_en   = 1'b0;
`ifdef MYMINIMAC_TX_PAD_EN
      sent_d      = sent_q;
`endif
      unique case (state_q)
         StIdle: begin
            // armed_q keeps the first edge after reset release idle.
            if (armed_q && tx_valid) begin
               if (tx_count == 11'd0) begin
                  state_d = StLast;
               end else begin
                  adr_d       = tx_adr;
                  remaining_d = (tx_count > MTU) ? MTU : tx_count;
`ifdef MYMINIMAC_TX_PAD_EN
                  sent_d      = '0;
`endif
                  state_d     = StFetch;
               end
            end
         end
         StFetch: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            if (wbm_ack_i) begin
               load    = 1'b1;
               adr_d   = adr_q + 30'd1;
               tx_next = 1'b1;
               state_d = StUnpack;
            end
         end
         StUnpack: begin
            unpack_en = 1'b1;
            fifo_data = unpack_byte;
            if (!fifo_full) begin
               fifo_we     = 1'b1;
               remaining_d = remaining_q - 11'd1;
`ifdef MYMINIMAC_TX_PAD_EN
               sent_d      = sat_inc11(sent_q);
`endif
               if (remaining_q == 11'd1) begin
                  // Any bytes left in the current word are dropped here.
`ifdef MYMINIMAC_TX_PAD_EN
                  state_d = (sent_d < {4'd0, MINLEN}) ? StPad : StLast;
`else
                  state_d = StLast;
`endif
               end else if (byte_idx == 2'd3) begin
                  state_d = StFetch;
               end
            end
         end
`ifdef MYMINIMAC_TX_PAD_EN
         StPad: begin
            if (!fifo_full) begin
               fifo_we = 1'b1;
               sent_d  = sat_inc11(sent_q);
               if (sent_d >= {4'd0, MINLEN}) begin
                  state_d = StLast;
               end
            end
         end
`endif
         StLast: begin
            fifo_data = EofMarker;
            if (!fifo_full) begin
               fifo_we  = 1'b1;
               fifo_eof = 1'b1;
               tx_done  = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q     <= StIdle;
         adr_q       <= '0;
         remaining_q <= '0;
         armed_q     <= 1'b0;
`ifdef MYMINIMAC_TX_PAD_EN
         sent_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         adr_q       <= adr_d;
         remaining_q <= remaining_d;
         armed_q     <= 1'b1;
`ifdef MYMINIMAC_TX_PAD_EN
         sent_q      <= sent_d;
`endif
      end
   end

endmodule

// File: tb/tb_myminimac_tx.sv
`timescale 1ns/1ps
module tb_myminimac_tx;

   localparam int Mtu    = 1530;
   localparam int Minlen = 60;
`ifdef MYMINIMAC_TX_PAD_EN
   localparam bit PadEn = 1'b1;
`else
   localparam bit PadEn = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        tx_valid = 1'b0;
   logic [29:0] tx_adr = '0;
   logic [10:0] tx_count = '0;
   logic        tx_next, tx_done;
   logic [31:0] wbm_adr_o;
   logic        wbm_cyc_o, wbm_stb_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;
   logic        fifo_we, fifo_eof;
   logic [7:0]  fifo_data;
   logic        fifo_full = 1'b0;

   int checks = 0;
   int errors = 0;

   int wait_target = 1;
   int wait_cnt = 0;
   bit rand_full = 1'b0;
   bit force_full = 1'b0;

   logic [31:0] mem [logic [29:0]];
   logic [8:0]  got_q[$];
   logic [31:0] got_adr[$];
   int next_cnt = 0;
   int done_cnt = 0;
   int bp_viol = 0;

   myminimac_tx dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .tx_valid  (tx_valid),
      .tx_adr    (tx_adr),
      .tx_count  (tx_count),
      .tx_next   (tx_next),
      .tx_done   (tx_done),
      .wbm_adr_o (wbm_adr_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .fifo_we   (fifo_we),
      .fifo_data (fifo_data),
      .fifo_eof  (fifo_eof),
      .fifo_full (fifo_full)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Wishbone slave with a programmable number of wait cycles.
   always @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         wbm_ack_i <= 1'b0;
         wait_cnt  <= 0;
      end else begin
         wbm_ack_i <= 1'b0;
         if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            if (wait_cnt >= wait_target) begin
               wbm_ack_i <= 1'b1;
               wbm_dat_i <= mem_word(wbm_adr_o[31:2]);
               wait_cnt  <= 0;
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end
      end
   end

   always @(posedge sys_clk) begin
      #1;
      fifo_full = force_full | (rand_full && ($urandom_range(0, 3) == 0));
   end

   always @(negedge sys_clk) begin
      if (fifo_we) got_q.push_back({fifo_eof, fifo_data});
      if ((fifo_we && fifo_full) || (fifo_eof && !fifo_we)) bp_viol++;
      if (tx_next) begin
         next_cnt++;
         got_adr.push_back(wbm_adr_o);
      end
      if (tx_done) done_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_frame(input string name, input logic [29:0] adr, input logic [10:0] cnt,
                            input int wt, input bit rf, input bit do_stall, input bit drop_early);
      logic [8:0]  exp_q[$];
      logic [31:0] exp_adr[$];
      int n, fetches, sw, ss, bad;
      bit seen, stalled;
      n = (int'(cnt) > Mtu) ? Mtu : int'(cnt);
      for (int i = 0; i < n; i++) begin
         logic [31:0] w;
         w = mem_word(adr + 30'(i / 4));
         exp_q.push_back({1'b0, 8'(w >> (8 * (3 - i % 4)))});
      end
      if (PadEn && n > 0) while (exp_q.size() < Minlen) exp_q.push_back(9'h000);
      exp_q.push_back(9'h100);
      fetches = (n + 3) / 4;
      for (int k = 0; k < fetches; k++) exp_adr.push_back({adr + 30'(k), 2'b00});

      @(posedge sys_clk); #1;
      got_q.delete(); got_adr.delete();
      next_cnt = 0; done_cnt = 0; bp_viol = 0;
      wait_target = wt; rand_full = rf; force_full = 1'b0;
      tx_adr = adr; tx_count = cnt; tx_valid = 1'b1;
      seen = 1'b0; stalled = 1'b0; sw = 0; ss = 0;
      for (int c = 0; c < 20000 && !seen; c++) begin
         @(negedge sys_clk);
         if (drop_early && fifo_we) tx_valid = 1'b0;
         if (do_stall && !stalled && fifo_we) begin
            stalled = 1'b1;
            force_full = 1'b1;
            for (int s = 0; s < 10; s++) begin
               @(negedge sys_clk);
               if (fifo_we) sw++;
               if (wbm_stb_o) ss++;
            end
            force_full = 1'b0;
         end
         if (tx_done) begin
            seen = 1'b1;
            tx_valid = 1'b0;
         end
      end
      tx_valid = 1'b0; rand_full = 1'b0; force_full = 1'b0;
      repeat (4) @(negedge sys_clk);

      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s done_timeout: got no tx_done, required one within 20000 cycles", name);
      end
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL %s push_count: got %0d pushes, required %0d", name, got_q.size(),
                  exp_q.size());
      end
      bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s push_data[%0d]: got eof/byte %h, required %h", name, bad, got_q[bad],
                  exp_q[bad]);
      end
      checks++;
      if (next_cnt !== fetches) begin
         errors++;
         $display("FAIL %s tx_next_count: got %0d, required %0d", name, next_cnt, fetches);
      end
      bad = (got_adr.size() == exp_adr.size()) ? -1 : 0;
      for (int i = 0; i < got_adr.size() && i < exp_adr.size(); i++)
         if (bad < 0 && got_adr[i] !== exp_adr[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s bus_address[%0d]: got %0d addresses, first differing entry %h, required %h",
                  name, bad, got_adr.size(), (bad < got_adr.size()) ? got_adr[bad] : 32'hx,
                  (bad < exp_adr.size()) ? exp_adr[bad] : 32'hx);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s tx_done_count: got %0d, required 1", name, done_cnt);
      end
      checks++;
      if (bp_viol !== 0) begin
         errors++;
         $display("FAIL %s push_protocol: got %0d bad push cycles, required 0", name, bp_viol);
      end
      if (do_stall) begin
         checks++;
         if (sw !== 0 || ss !== 0 || !stalled) begin
            errors++;
            $display("FAIL %s stall: got we=%0d stb=%0d stalled=%0d, required 0 0 1", name, sw, ss,
                     stalled);
         end
      end
   endtask

   task automatic test_reset;
      sys_rst = 1'b0;
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, fifo_we, fifo_eof, tx_next, tx_done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_controls: got cyc,stb,we,eof,next,done=%b, required 000000",
                  {wbm_cyc_o, wbm_stb_o, fifo_we, fifo_eof, tx_next, tx_done});
      end
      checks++;
      if (wbm_adr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_adr: got %h, required 00000000", wbm_adr_o);
      end
   endtask

   task automatic test_release_latency;
      tx_count = 11'd0; tx_adr = '0; tx_valid = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (fifo_we !== 1'b0) begin
         errors++;
         $display("FAIL release_edge1: got fifo_we=%b, required 0", fifo_we);
      end
      @(negedge sys_clk);
      checks++;
      if ({fifo_we, fifo_eof, tx_done, wbm_cyc_o} !== 4'b1110) begin
         errors++;
         $display("FAIL release_edge2: got we,eof,done,cyc=%b, required 1110",
                  {fifo_we, fifo_eof, tx_done, wbm_cyc_o});
      end
      tx_valid = 1'b0;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_reset_mid_fetch;
      int guard, we_cnt, cyc_cnt;
      @(posedge sys_clk); #1;
      wait_target = 40; rand_full = 1'b0; force_full = 1'b0;
      tx_adr = 30'h300; tx_count = 11'd16; tx_valid = 1'b1;
      guard = 0;
      while (!wbm_cyc_o && guard < 50) begin
         @(negedge sys_clk);
         guard++;
      end
      checks++;
      if (wbm_cyc_o !== 1'b1) begin
         errors++;
         $display("FAIL midreset_fetch_start: got cyc=%b, required 1", wbm_cyc_o);
      end
      repeat (3) @(negedge sys_clk);
      #2 sys_rst = 1'b0;
      #1;
      checks++;
      if ({wbm_cyc_o, wbm_stb_o} !== 2'b00 || wbm_adr_o !== 32'h0) begin
         errors++;
         $display("FAIL midreset_async: got cyc,stb=%b adr=%h, required 00 00000000",
                  {wbm_cyc_o, wbm_stb_o}, wbm_adr_o);
      end
      tx_valid = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b1;
      we_cnt = 0; cyc_cnt = 0;
      repeat (20) begin
         @(negedge sys_clk);
         if (fifo_we) we_cnt++;
         if (wbm_cyc_o) cyc_cnt++;
      end
      checks++;
      if (we_cnt !== 0 || cyc_cnt !== 0) begin
         errors++;
         $display("FAIL midreset_idle: got we=%0d cyc=%0d cycles, required 0 0", we_cnt, cyc_cnt);
      end
      wait_target = 1;
   endtask

   task automatic test_basic;
      mem[30'h100] = 32'h1122_3344;
      mem[30'h101] = 32'h5566_7788;
      run_frame("basic", 30'h100, 11'd8, 1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_partial_word;
      mem[30'h200] = 32'hAABB_CCDD;
      mem[30'h201] = 32'hEE00_0000;
      run_frame("partial", 30'h200, 11'd5, 1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_stall;
      run_frame("stall", 30'h280, 11'd12, 2, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_pad;
      run_frame("pad14", 30'h040, 11'd14, 0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_mtu;
      run_frame("mtu", 30'h1000, 11'd2000, 0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_zero_count;
      run_frame("zero", 30'h500, 11'd0, 1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_wrap;
      run_frame("wrap", 30'h3FFF_FFFE, 11'd12, 1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      for (int f = 0; f < 6; f++) begin
         logic [29:0] a;
         a = 30'($urandom);
         run_frame("random", a, 11'($urandom_range(1, 90)), int'($urandom_range(0, 3)), 1'b1,
                   1'b0, f[0]);
      end
   endtask

   initial begin
      test_reset();
      test_release_latency();
      test_basic();
      test_partial_word();
      test_stall();
      test_pad();
      test_mtu();
      test_zero_count();
      test_wrap();
      test_back_to_back();
      test_reset_mid_fetch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/myminimac_tx.md
MYMINIMAC_TX -- requirements
Module: myminimac_tx

Interface
REQ-001 SHALL have parameter MTU, default 11'd1530, maximum bytes taken from memory per frame; longer requests are truncated.
REQ-002 SHALL have parameter MINLEN, default 7'd60, minimum frame length in bytes used when padding is compiled in.
REQ-003 SHALL have port sys_clk  in  1  system clock; the only clock.
REQ-004 SHALL have port sys_rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_valid  in  1  frame descriptor valid; held high until tx_done.
REQ-006 SHALL have port tx_adr  in  30  word address of the first frame word.
REQ-007 SHALL have port tx_count  in  11  frame length in bytes.
REQ-008 SHALL have port tx_next  out  1  one-cycle pulse per word fetched.
REQ-009 SHALL have port tx_done  out  1  one-cycle pulse when the EOF marker is pushed.
REQ-010 SHALL have ports wbm_adr_o out 32, wbm_cyc_o out 1, wbm_stb_o out 1, wbm_dat_i in 32 and wbm_ack_i in 1, forming a Wishbone read master.
REQ-011 SHALL have ports fifo_we out 1, fifo_data out 8, fifo_eof out 1 and fifo_full in 1, forming the byte push toward the RMII tx FIFO.

Function
REQ-012 SHALL implement the FSM states IDLE, FETCH, UNPACK, PAD and LAST.
REQ-013 IDLE: on tx_valid with tx_count!=0, SHALL latch adr<=tx_adr and remaining<=min(tx_count,MTU), then go to FETCH.
REQ-014 IDLE: on tx_valid with tx_count==0, SHALL go to LAST and SHALL NOT perform any bus cycle.
REQ-015 FETCH: SHALL hold cyc=stb=1 with wbm_adr_o={adr,2'b00}; on ack, SHALL latch wbm_dat_i, set adr<=adr+1, pulse tx_next and go to UNPACK.
REQ-016 UNPACK: SHALL send bytes big-endian ([31:24] first); each cycle with fifo_full=0 SHALL set fifo_we=1 and decrement remaining by 1.
REQ-017 UNPACK: SHALL go to FETCH after 4 bytes while remaining>0.
REQ-018 UNPACK: when remaining reaches 0, SHALL go to PAD if padding is enabled and sent<MINLEN, else to LAST.
REQ-019 UNPACK: bytes left in a partial last word SHALL be discarded.
REQ-020 Backpressure: while fifo_full=1, fifo_we SHALL be 0 and the byte index and counters SHALL hold.
REQ-021 The bus SHALL never be strobed while fifo_full=1 and a byte is pending.
REQ-022 PAD: SHALL push 8'h00 bytes, under the same backpressure rule, until sent==MINLEN, then go to LAST.
REQ-023 LAST: when fifo_full=0, SHALL assert fifo_we=1, fifo_eof=1 and fifo_data=8'h00 for one cycle, pulse tx_done and go to IDLE.
REQ-024 Counters: remaining SHALL be 11 bits and sent SHALL be 11 bits saturating at 2047; adr wrap-around from 30'h3FFFFFFF to 0 SHALL be permitted.
REQ-025 tx_valid dropping mid-frame SHALL be ignored; the frame SHALL complete.

Reset
REQ-026 On reset assertion, the FSM SHALL go to IDLE immediately; wbm_cyc_o, wbm_stb_o, fifo_we, fifo_eof, tx_next and tx_done SHALL be 0; wbm_adr_o, counters and the data latch SHALL be 0.
REQ-027 Reset asserted mid-bus-cycle SHALL drop cyc/stb asynchronously, and no EOF SHALL be emitted.
REQ-028 After release, the first action SHALL occur no earlier than the second sys_clk edge.

Configuration
REQ-029 Macro MYMINIMAC_TX_PAD_EN: when defined, frames shorter than MINLEN SHALL be zero-padded to MINLEN before EOF.
REQ-030 Without MYMINIMAC_TX_PAD_EN, the PAD state and MINLEN logic SHALL be absent, and EOF SHALL follow the last data byte.

Structure
REQ-031 Package myminimac_pkg SHALL hold the state encoding (3 bits), the MTU and MINLEN defaults, and the EOF marker value.
REQ-032 The block SHALL have one sub-module, myminimac_tx_unpack: a 32-to-8 big-endian shifter with a 2-bit byte index and hold-on-full.

Verification
REQ-033 tx_adr=0x100, tx_count=8, memory 0x11223344 and 0x55667788, ack after 1 wait -> fifo bytes 11..88 then EOF; 2 tx_next; wbm_adr_o 0x400, 0x404; 1 tx_done.
REQ-034 tx_count=5, memory 0xAABBCCDD and 0xEE000000 -> bytes AA BB CC DD EE then EOF; the next 3 bytes discarded.
REQ-035 fifo_full held high for 10 cycles mid-word -> no fifo_we during the stall, no new bus cycle, byte order intact.
REQ-036 With PAD_EN, tx_count=14 -> 14 data bytes + 46 bytes of 00 + EOF; without PAD_EN -> 14 bytes + EOF.
REQ-037 tx_count=2000 -> exactly 1530 bytes and 383 fetches, then EOF.
REQ-038 Reset low during FETCH with ack pending -> cyc/stb 0 within the same cycle; after release with tx_valid=0 -> IDLE and no EOF.
